// File: rtl/codec_cfg_pkg.sv
// Shared state encodings and the WM8731 power-up register table for codec_cfg_sequencer.
package codec_cfg_pkg;

  localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h1A;
  localparam int unsigned INIT_LEN         = 11;

  typedef enum logic [2:0] {
    BW_IDLE, BW_START, BW_BIT, BW_ACK, BW_STOP, BW_GAP
  } bw_state_t;

  typedef enum logic [2:0] {
    SQ_IDLE, SQ_LOAD, SQ_BYTE, SQ_WAIT, SQ_DONE, SQ_ERR
  } sq_state_t;

  // Each entry is {reg[6:0], data[8:0]}
  localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
    {7'd15, 9'h000}, {7'd0, 9'h017}, {7'd1, 9'h017}, {7'd2, 9'h079},
    {7'd3,  9'h079}, {7'd4, 9'h012}, {7'd5, 9'h000}, {7'd6, 9'h000},
    {7'd7,  9'h002}, {7'd8, 9'h000}, {7'd9, 9'h001}
  };

endpackage

// File: rtl/i2c_byte_writer.sv
// One I2C byte with optional START before and STOP+GAP after; owns the quarter tick.
// I2C_CLK_STRETCH_EN adds sclk_in and holds the high quarters until SCL reads high.
module i2c_byte_writer
  import codec_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 333,
  parameter int unsigned GAP_QUARTERS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] byte_in,
  input  logic       first,
  input  logic       last,
  input  logic       sdat_in,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       sclk_in,
`endif
  output logic       sclk,
  output logic       sdat_oe,
  output logic       done,
  output logic       nack
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = (GAP_QUARTERS > 1) ? $clog2(GAP_QUARTERS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_QUARTERS - 1);

  bw_state_t     state, state_nx;
  logic [1:0]    q, q_nx;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          stop_r, nack_r, hold, tick;

`ifdef I2C_CLK_STRETCH_EN
  assign hold = ((state == BW_BIT) || (state == BW_ACK)) && q[1] && !sclk_in;
`else
  assign hold = 1'b0;
`endif
  assign tick = (cnt == CNT_MAX) && !hold;
  assign nack = nack_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= BW_IDLE;
      q       <= '0;
      cnt     <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      stop_r  <= 1'b0;
      nack_r  <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      if ((state == BW_IDLE) && go) cnt <= '0;
      else if (!hold)               cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
      if ((state == BW_IDLE) && go) begin
        shreg   <= byte_in;
        stop_r  <= last;
        nack_r  <= 1'b0;
        bit_cnt <= 3'd7;
      end
      if (tick) begin
        case (state)
          BW_BIT:  if (q == 2'd3) begin
                     shreg   <= {shreg[6:0], 1'b0};
                     bit_cnt <= bit_cnt - 3'd1;
                   end
          BW_ACK:  if (q == 2'd2) nack_r <= sdat_in;
          BW_STOP: gap_cnt <= '0;
          BW_GAP:  gap_cnt <= gap_cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state;
    q_nx     = q;
    case (state)
      BW_IDLE:  if (go) begin
                  state_nx = first ? BW_START : BW_BIT;
                  q_nx     = '0;
                end
      BW_START: if (tick) begin
                  q_nx = q + 2'd1;
                  if (q == 2'd1) begin state_nx = BW_BIT; q_nx = '0; end
                end
      BW_BIT:   if (tick) begin
                  q_nx = q + 2'd1;
                  if ((q == 2'd3) && (bit_cnt == 3'd0)) state_nx = BW_ACK;
                end
      BW_ACK:   if (tick) begin
                  q_nx = q + 2'd1;
                  if (q == 2'd3) state_nx = (nack_r || stop_r) ? BW_STOP : BW_IDLE;
                end
      BW_STOP:  if (tick) begin
                  q_nx = q + 2'd1;
                  if (q == 2'd2) begin state_nx = BW_GAP; q_nx = '0; end
                end
      BW_GAP:   if (tick && (gap_cnt == GAP_MAX)) state_nx = BW_IDLE;
      default:  state_nx = BW_IDLE;
    endcase
  end

  always_comb begin
    sclk    = 1'b1;
    sdat_oe = 1'b0;
    case (state)
      BW_START: begin sclk = (q == 2'd0); sdat_oe = 1'b1; end
      BW_BIT:   begin sclk = q[1]; sdat_oe = ~shreg[7]; end
      BW_ACK:   sclk = q[1];
      BW_STOP:  begin sclk = (q != 2'd0); sdat_oe = (q != 2'd2); end
      default:  ;
    endcase
    // A NACK or final byte finishes after STOP+GAP; otherwise right after the ACK slot
    done = tick && (((state == BW_ACK) && (q == 2'd3) && !nack_r && !stop_r) ||
                    ((state == BW_GAP) && (gap_cnt == GAP_MAX)));
  end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// WM8731 configuration sequencer: init table replay, retry, and runtime write arbitration.
// I2C_CLK_STRETCH_EN adds i2c_sclk_in and makes i2c_sclk an open-drain release enable.
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 333,
  parameter logic [6:0]  DEV_ADDR     = DEV_ADDR_DEFAULT,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned GAP_QUARTERS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cfg_req,
  input  logic [6:0] cfg_reg,
  input  logic [8:0] cfg_data,
  output logic       cfg_ack,
  output logic       i2c_sclk,
  input  logic       i2c_sdat_in,
`ifdef I2C_CLK_STRETCH_EN
  input  logic       i2c_sclk_in,
`endif
  output logic       i2c_sdat_oe,
  output logic       busy,
  output logic       init_done,
  output logic       error
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);

  sq_state_t     state, state_nx;
  logic [3:0]    idx;
  logic [1:0]    byte_cnt;
  logic [RW-1:0] attempt, attempt_inc;
  logic [6:0]    cur_reg;
  logic [8:0]    cur_data;
  logic          runtime, table_pend;
  logic          accept, last_entry, exhausted;
  logic          wr_go, wr_first, wr_last, wr_done, wr_nack;
  logic [7:0]    wr_byte;

  assign accept      = (state == SQ_IDLE) && !table_pend && cfg_req && init_done;
  assign last_entry  = (idx == 4'(INIT_LEN - 1));
  assign attempt_inc = attempt + 1'b1;
  assign exhausted   = (attempt_inc == RW'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SQ_IDLE;
      idx        <= '0;
      byte_cnt   <= '0;
      attempt    <= '0;
      cur_reg    <= '0;
      cur_data   <= '0;
      runtime    <= 1'b0;
      table_pend <= 1'b1;
      init_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        SQ_IDLE: if (table_pend) begin
                   table_pend <= 1'b0;
                   idx        <= '0;
                   runtime    <= 1'b0;
                   init_done  <= 1'b0;
                   error      <= 1'b0;
                 end else if (accept) begin
                   cur_reg  <= cfg_reg;
                   cur_data <= cfg_data;
                   runtime  <= 1'b1;
                   byte_cnt <= '0;
                   attempt  <= '0;
                 end
        SQ_LOAD: begin
                   {cur_reg, cur_data} <= INIT_TABLE[idx];
                   byte_cnt            <= '0;
                   attempt             <= '0;
                 end
        SQ_WAIT: if (wr_done) begin
                   if (wr_nack) begin
                     attempt  <= attempt_inc;
                     byte_cnt <= '0;
                     if (exhausted) error <= 1'b1;
                   end else if (byte_cnt != 2'd2) begin
                     byte_cnt <= byte_cnt + 2'd1;
                   end else if (!runtime && !table_pend) begin
                     if (last_entry) init_done <= 1'b1;
                     else            idx       <= idx + 4'd1;
                   end
                 end
        default: ;
      endcase
      // Placed last so a start landing on the servicing cycle is not lost
      if (start) table_pend <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      SQ_IDLE: if (table_pend) state_nx = SQ_LOAD;
               else if (accept) state_nx = SQ_BYTE;
      SQ_LOAD: state_nx = SQ_BYTE;
      SQ_BYTE: state_nx = SQ_WAIT;
      SQ_WAIT: if (wr_done) begin
                 if (wr_nack)                                 state_nx = exhausted ? SQ_ERR : SQ_BYTE;
                 else if (byte_cnt != 2'd2)                   state_nx = SQ_BYTE;
                 else if (runtime || table_pend || last_entry) state_nx = SQ_DONE;
                 else                                         state_nx = SQ_LOAD;
               end
      SQ_DONE: state_nx = SQ_IDLE;
      SQ_ERR:  state_nx = SQ_IDLE;
      default: state_nx = SQ_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != SQ_IDLE);
    cfg_ack  = accept;
    wr_go    = (state == SQ_BYTE);
    wr_first = (byte_cnt == 2'd0);
    wr_last  = (byte_cnt == 2'd2);
    case (byte_cnt)
      2'd0:    wr_byte = {DEV_ADDR, 1'b0};
      2'd1:    wr_byte = {cur_reg, cur_data[8]};
      default: wr_byte = cur_data[7:0];
    endcase
  end

  i2c_byte_writer #(
    .CLK_DIV      (CLK_DIV),
    .GAP_QUARTERS (GAP_QUARTERS)
  ) u_writer (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (wr_go),
    .byte_in (wr_byte),
    .first   (wr_first),
    .last    (wr_last),
    .sdat_in (i2c_sdat_in),
`ifdef I2C_CLK_STRETCH_EN
    .sclk_in (i2c_sclk_in),
`endif
    .sclk    (i2c_sclk),
    .sdat_oe (i2c_sdat_oe),
    .done    (wr_done),
    .nack    (wr_nack)
  );

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: I2C slave model feeding a frame scoreboard, directed steps.
module tb_codec_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, cfg_req, cfg_ack;
  logic [6:0] cfg_reg;
  logic [8:0] cfg_data;
  logic       i2c_sclk, i2c_sdat_in, i2c_sdat_oe, busy, init_done, error;
  logic       slave_low = 1'b0;

  int checks = 0, failures = 0;
  int good_frames = 0, nacks = 0, stops = 0, ack_count = 0;
  int nack_at = -1, nack_left = 0;
  int bitn = 0, byten = 0;
  logic in_frame = 1'b0, frame_nack = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0]  shift;
  logic [23:0] frame;
  logic [23:0] sb[$];

  int unsigned tbl_reg [11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int unsigned tbl_dat [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                                'h000, 'h000, 'h002, 'h000, 'h001};

  always #5 clk = ~clk;
  assign i2c_sdat_in = ~(i2c_sdat_oe | slave_low);

  codec_cfg_sequencer #(.CLK_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_req     (cfg_req),
    .cfg_reg     (cfg_reg),
    .cfg_data    (cfg_data),
    .cfg_ack     (cfg_ack),
    .i2c_sclk    (i2c_sclk),
    .i2c_sdat_in (i2c_sdat_in),
`ifdef I2C_CLK_STRETCH_EN
    .i2c_sclk_in (i2c_sclk),
`endif
    .i2c_sdat_oe (i2c_sdat_oe),
    .busy        (busy),
    .init_done   (init_done),
    .error       (error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] fr(input int unsigned r, input int unsigned d);
    logic [6:0] rr;
    logic [8:0] dd;
    rr = 7'(r);
    dd = 9'(d);
    return {8'h34, rr, dd};
  endfunction

  task automatic push_table(input int n);
    for (int i = 0; i < n; i++) sb.push_back(fr(tbl_reg[i], tbl_dat[i]));
  endtask

  // Slave model: samples the bus on the falling clock edge, ACKs unless a NACK is armed
  always @(negedge clk) begin : slave
    logic sda;
    logic [23:0] exp;
    sda = i2c_sdat_in;
    if (!rst_n) begin
      slave_low = 1'b0;
      in_frame  = 1'b0;
      bitn      = 0;
      prev_scl  = 1'b1;
      prev_sda  = 1'b1;
    end else begin
      if (prev_scl && i2c_sclk && prev_sda && !sda) begin
        in_frame = 1'b1; bitn = 0; byten = 0; frame_nack = 1'b0;
      end else if (prev_scl && i2c_sclk && !prev_sda && sda) begin
        stops++;
        if (in_frame && byten == 3 && !frame_nack) begin
          exp = (sb.size() > 0) ? sb.pop_front() : 24'hFFFFFF;
          chk("frame", frame, exp);
          good_frames++;
        end
        in_frame  = 1'b0;
        slave_low = 1'b0;
      end else if (in_frame && !prev_scl && i2c_sclk) begin
        if (bitn < 8) begin shift = {shift[6:0], sda}; bitn++; end
        else bitn = 9;
      end else if (in_frame && prev_scl && !i2c_sclk) begin
        if (bitn == 8) begin
          frame = {frame[15:0], shift};
          if (byten == 0 && good_frames == nack_at && nack_left > 0) begin
            nack_left--; nacks++; frame_nack = 1'b1; slave_low = 1'b0;
          end else slave_low = 1'b1;
        end else if (bitn == 9) begin
          slave_low = 1'b0; bitn = 0; byten++;
        end
      end
      prev_scl = i2c_sclk;
      prev_sda = sda;
    end
  end

  always @(negedge clk) if (rst_n && cfg_ack) ack_count++;

  task automatic wait_quiet(input string tag, input int budget);
    int q = 0;
    int n = 0;
    while (q < 8 && n < budget) begin
      @(negedge clk);
      n++;
      if (busy) q = 0; else q++;
    end
    chk(tag, 32'(q >= 8), 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic req_write(input logic [6:0] r, input logic [8:0] d, input int budget,
                           output logic seen, output logic done_at_ack);
    int n = 0;
    seen = 1'b0;
    done_at_ack = 1'b0;
    @(posedge clk); #1 cfg_req = 1'b1; cfg_reg = r; cfg_data = d;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (cfg_ack) begin seen = 1'b1; done_at_ack = init_done; end
    end
    @(posedge clk); #1 cfg_req = 1'b0;
  endtask

  initial begin
    int base_ack, base_nack, base_stop, base_good, n;
    logic seen, dack;
    rst_n = 1'b0; start = 1'b0; cfg_req = 1'b0; cfg_reg = '0; cfg_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sclk", i2c_sclk, 1);
    chk("rst_oe", i2c_sdat_oe, 0);
    chk("rst_ack", cfg_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_error", error, 0);

    // Auto-run of the init table after reset
    push_table(11);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_quiet("init_timeout", 20000);
    chk("init_done", init_done, 1);
    chk("init_busy", busy, 0);
    chk("init_error", error, 0);
    chk("init_frames", good_frames, 11);
    chk("init_sb_empty", sb.size(), 0);

    // Runtime write after init
    base_ack = ack_count;
    sb.push_back(fr(2, 'h07F));
    req_write(7'd2, 9'h07F, 200, seen, dack);
    chk("rt_ack_seen", seen, 1);
    wait_quiet("rt_timeout", 2000);
    chk("rt_ack_count", ack_count - base_ack, 1);
    chk("rt_error", error, 0);
    chk("rt_sb_empty", sb.size(), 0);

    // Request held during a table replay waits until init_done
    base_ack = ack_count;
    push_table(11);
    sb.push_back(fr(5, 'h1AB));
    pulse_start();
    repeat (20) @(posedge clk);
    req_write(7'd5, 9'h1AB, 20000, seen, dack);
    chk("hold_ack_seen", seen, 1);
    chk("hold_done_at_ack", dack, 1);
    wait_quiet("hold_timeout", 2000);
    chk("hold_ack_count", ack_count - base_ack, 1);
    chk("hold_sb_empty", sb.size(), 0);

    // R4 address byte always NACKed
    base_nack = nacks; base_stop = stops;
    nack_at = good_frames + 5; nack_left = 100;
    push_table(5);
    pulse_start();
    wait_quiet("nack3_timeout", 20000);
    chk("nack3_attempts", nacks - base_nack, 3);
    chk("nack3_stops", stops - base_stop, 8);
    chk("nack3_error", error, 1);
    chk("nack3_init_done", init_done, 0);
    chk("nack3_sb_empty", sb.size(), 0);

    // R4 NACKed once, then accepted
    base_nack = nacks;
    nack_at = good_frames + 5; nack_left = 1;
    push_table(11);
    pulse_start();
    wait_quiet("nack1_timeout", 20000);
    chk("nack1_attempts", nacks - base_nack, 1);
    chk("nack1_error", error, 0);
    chk("nack1_init_done", init_done, 1);
    chk("nack1_sb_empty", sb.size(), 0);

    // start pulsed mid-frame of R6: frame completes, table replays from R15
    nack_left = 0;
    base_good = good_frames;
    push_table(8);
    push_table(11);
    pulse_start();
    n = 0;
    while (!(good_frames == base_good + 7 && in_frame && byten >= 1) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("restart_reach_r6", 32'(n < 20000), 1);
    pulse_start();
    n = 0;
    while (good_frames < base_good + 9 && n < 20000) begin @(negedge clk); n++; end
    chk("restart_replay_init_done", init_done, 0);
    wait_quiet("restart_timeout", 20000);
    chk("restart_init_done", init_done, 1);
    chk("restart_sb_empty", sb.size(), 0);

    // Reset mid-bit of a runtime write
    req_write(7'd4, 9'h0AA, 200, seen, dack);
    n = 0;
    while (!(in_frame && bitn == 3) && n < 2000) begin @(negedge clk); n++; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_sclk", i2c_sclk, 1);
    chk("midrst_oe", i2c_sdat_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_init_done", init_done, 0);
    sb.delete();
    push_table(11);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_quiet("midrst_timeout", 20000);
    chk("midrst_reinit", init_done, 1);
    chk("midrst_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
